// File: rtl/ca_pkg.sv
// Types and constants shared by the cellular-automaton core and its display path.
package ca_pkg;
  localparam int GRID_N = 8;

  typedef logic [GRID_N-1:0][GRID_N-1:0] grid_t;

  typedef enum logic [1:0] {LOAD, SHIFT, LATCH, HOLD} scan_state_t;
endpackage

// File: rtl/shift_out16.sv
// MSB-first 16-bit serialiser with a divided shift clock; done pulses during the
// final cycle of bit 0 so the caller can move on at the very next edge.
module shift_out16 #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        load,
  input  logic [15:0] word,
  output logic        ser_data,
  output logic        ser_clk,
  output logic        done
);
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [15:0]   word_reg;
  logic [4:0]    bit_reg;
  logic [DW-1:0] div_reg;
  logic          phase_reg;
  logic          active_reg;
  logic          half_end;

  assign half_end = active_reg && (div_reg == DIV_LAST);
  assign done     = half_end && phase_reg && (bit_reg == 5'd0);

  always_ff @(posedge clk) begin
    if (srst) begin
      word_reg   <= '0;
      bit_reg    <= 5'd15;
      div_reg    <= '0;
      phase_reg  <= 1'b0;
      active_reg <= 1'b0;
      ser_data   <= 1'b0;
      ser_clk    <= 1'b0;
    end else if (load) begin
      // word_reg always holds the bits still to be sent, next one at [15]
      ser_data   <= word[15];
      word_reg   <= word << 1;
      bit_reg    <= 5'd15;
      div_reg    <= '0;
      phase_reg  <= 1'b0;
      active_reg <= 1'b1;
      ser_clk    <= 1'b0;
    end else if (active_reg) begin
      if (half_end) begin
        div_reg <= '0;
        if (!phase_reg) begin
          phase_reg <= 1'b1;
          ser_clk   <= 1'b1;
        end else begin
          phase_reg <= 1'b0;
          ser_clk   <= 1'b0;
          if (bit_reg == 5'd0) begin
            active_reg <= 1'b0;
            ser_data   <= 1'b0;
          end else begin
            bit_reg  <= bit_reg - 5'd1;
            ser_data <= word_reg[15];
            word_reg <= word_reg << 1;
          end
        end
      end else begin
        div_reg <= div_reg + 1'b1;
      end
    end
  end
endmodule

// File: rtl/grid_scanner.sv
// Row-scans a per-frame snapshot of the 8x8 grid into two chained 8-bit
// latching shift registers: row-select byte first, then the column byte.
module grid_scanner
  import ca_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int ROW_HOLD = 2000
) (
  input  logic       clk,
  input  logic       restart,
  input  grid_t      grid_in,
  input  logic       blank,
  output logic       ser_data,
  output logic       ser_clk,
  output logic       ser_latch,
  output logic [2:0] row_idx,
  output logic       frame_done
);
  localparam int CMAX = (ROW_HOLD > CLK_DIV) ? ROW_HOLD : CLK_DIV;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(ROW_HOLD - 1);

  scan_state_t   state_reg, state_next;
  logic [2:0]    row_reg, row_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  grid_t         snap_reg;
  logic [7:0]    row_bits;
  logic [15:0]   word;
  logic          load;
  logic          shift_done;
  logic          latch_next;
  logic          frame_done_next;

  // Row 0 reads the live grid because the snapshot is being taken in that same cycle.
  assign row_bits = (row_reg == 3'd0) ? grid_in[0] : snap_reg[row_reg];
  assign word     = {8'd1 << row_reg, blank ? 8'h00 : row_bits};
  assign load     = (state_reg == LOAD);
  assign row_idx  = row_reg;

  shift_out16 #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk      (clk),
    .srst     (restart),
    .load     (load),
    .word     (word),
    .ser_data (ser_data),
    .ser_clk  (ser_clk),
    .done     (shift_done)
  );

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      LOAD: begin
        state_next = SHIFT;
        cnt_next   = '0;
      end
      SHIFT: begin
        cnt_next = '0;
        if (shift_done) state_next = LATCH;
      end
      LATCH: begin
        if (cnt_reg == DIV_LAST) begin
          state_next = HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_reg == HOLD_LAST) begin
          state_next = LOAD;
          cnt_next   = '0;
          row_next   = row_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = LOAD;
    endcase
    latch_next      = (state_next == LATCH);
    frame_done_next = (state_next == HOLD) && (cnt_next == HOLD_LAST) &&
                      (row_reg == 3'(GRID_N - 1));
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      state_reg  <= LOAD;
      row_reg    <= 3'd0;
      cnt_reg    <= '0;
      ser_latch  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_reg  <= state_next;
      row_reg    <= row_next;
      cnt_reg    <= cnt_next;
      ser_latch  <= latch_next;
      frame_done <= frame_done_next;
      if (state_reg == LOAD && row_reg == 3'd0) snap_reg <= grid_in;
    end
  end
endmodule
